// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the 32-bit multicycle MIPS-style datapath: drives every
// register enable and mux select, flags illegal opcodes and counts retirements.
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // The branch decision is taken in the datapath from pc_write_cond and zero.
  logic unused_zero;
  assign unused_zero = zero;

  logic       ready;
  logic [3:0] next_state;
  logic       decode_illegal;
  logic       retire;
  logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, pc_write_cond_raw;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    next_state     = FETCH;
    decode_illegal = 1'b0;
    unique case (state)
      FETCH:  next_state = ready ? DECODE : FETCH;
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            next_state     = FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next_state = ready ? MEMWB : MEMRD;
      MEMWR:  next_state = ready ? FETCH : MEMWR;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ior_d             = 1'b0;
    mem_read          = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    reg_write_raw     = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    unique case (state)
      FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = ready;
        pc_write_raw = ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEMWR: begin
        mem_write_raw = 1'b1;
        ior_d         = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
      end
      ADDIWB: reg_write_raw = 1'b1;
      JUMP: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'b10;
      end
      default: ;
    endcase
  end

  // State sits at FETCH during reset, so the enables must be gated explicitly.
  assign pc_write      = pc_write_raw      & reset_n;
  assign pc_write_cond = pc_write_cond_raw & reset_n;
  assign ir_write      = ir_write_raw      & reset_n;
  assign reg_write     = reg_write_raw     & reset_n;
  assign mem_write     = mem_write_raw     & reset_n;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == ADDIWB) ||
                  (state == BRANCH) || (state == JUMP) || ((state == MEMWR) && ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= next_state;
      illegal_op <= (state == DECODE) && decode_illegal;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level model
// expands each opcode into its expected state path and output pattern.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  multicycle_control_unit #(.CNT_W(CNT_W), .MEM_WAIT_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clock = ~clock;

  logic [15:0] outs;
  assign outs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current instruction as a list of states to visit.
  logic [3:0] seq[$];
  int         idx;
  bit         cur_legal;
  logic [5:0] cur_op;
  int         exp_ret;
  bit         exp_ill;
  logic [5:0] directed[$];

  function automatic logic [15:0] exp_outs(input logic [3:0] s, input bit r);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (s)
      4'd0:  begin mr = 1; sb = 2'b01; irw = r; pw = r; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  task automatic new_instr();
    logic [5:0] op;
    if (directed.size() > 0) op = directed.pop_front();
    else if ($urandom_range(0, 4) != 0) begin
      case ($urandom_range(0, 5))
        0: op = LW;  1: op = SW;   2: op = RT;
        3: op = BEQ; 4: op = ADDI; default: op = JMP;
      endcase
    end else op = 6'($urandom);
    cur_op    = op;
    opcode    = op;
    cur_legal = 1'b1;
    case (op)
      LW:   seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      SW:   seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      RT:   seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      BEQ:  seq = '{4'd0, 4'd1, 4'd8};
      ADDI: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
      JMP:  seq = '{4'd0, 4'd1, 4'd11};
      default: begin seq = '{4'd0, 4'd1}; cur_legal = 1'b0; end
    endcase
    idx = 0;
  endtask

  task automatic advance(input bit r);
    logic [3:0] s = seq[idx];
    exp_ill = 1'b0;
    if ((s == 4'd0 || s == 4'd3 || s == 4'd5) && !r) return;
    idx++;
    if (idx == seq.size()) begin
      if (cur_legal) exp_ret = (exp_ret + 1) % (1 << CNT_W);
      else exp_ill = 1'b1;
      new_instr();
    end
  endtask

  task automatic step(input bit rnd);
    @(negedge clock);
    mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    check("state", 32'(state), 32'(seq[idx]));
    check("outputs", 32'(outs), 32'(exp_outs(seq[idx], mem_ready)));
    check("retired", 32'(retired), 32'(exp_ret));
    check("illegal_op", 32'(illegal_op), 32'(exp_ill));
    @(posedge clock);
    #1;
    advance(mem_ready);
  endtask

  task automatic check_in_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_enables", 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
  endtask

  initial begin
    bit reached;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_in_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_ret = 0;
    exp_ill = 1'b0;
    directed = '{LW, SW, RT, BEQ, JMP, 6'b111111};
    for (int i = 0; i < 16; i++) directed.push_back(ADDI);
    new_instr();

    for (int i = 0; i < 90; i++) step(1'b0);
    for (int i = 0; i < 600; i++) step(1'b1);

    // Mid-instruction reset while a lw waits in MEMRD.
    directed.push_back(LW);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step(1'b0);
      reached = (cur_op == LW) && (seq[idx] == 4'd3);
    end
    check("reach_memrd", 32'(reached), 32'd1);
    #2;
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_in_reset();
    @(negedge clock);
    check_in_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_ret = 0;
    exp_ill = 1'b0;
    new_instr();
    for (int i = 0; i < 150; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style sequencer for the 32-bit multicycle datapath.
- Drives every register enable and mux select: PC, IR, register file, memory, and the ALU operand/op selects.
- ALUOut and the other intermediate registers load every cycle; this block sequences what each one captures.
- Supports R-type, lw, sw, beq, addi, j.
- Adds a memory-ready wait handshake, illegal-opcode flagging and a retired-instruction counter.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = treat mem_ready as always 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag; used by the datapath with pc_write_cond, not by the FSM.
- mem_ready  input  1  memory access complete this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero.
- ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back select: 1 = MDR, 0 = ALUOut.
- reg_dst  output  1  destination register: 1 = rd, 0 = rt.
- reg_write  output  1  register-file write.
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU operand B: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = decode by funct.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding.
- illegal_op  output  1  one-cycle registered pulse.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
State encoding:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Codes 12-15 are unused.

Reset:
- Asynchronous on reset_n low: state = FETCH, retired = 0, illegal_op = 0.
- While reset_n = 0, pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced to 0.
- Reset mid-instruction abandons the instruction with no count.

Outputs:
- Combinational from state; every signal not listed below is 0.
- pc_write and ir_write in FETCH additionally depend on mem_ready.

Per-state outputs and next state:
- FETCH: mem_read = 1, ior_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write = pc_write = mem_ready. Go to DECODE if mem_ready, else stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH, and illegal_op = 1 next cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEMRD if opcode = 100011, else MEMWR.
- MEMRD: mem_read = 1, ior_d = 1. Go to MEMWB on mem_ready, else hold.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
- MEMWR: mem_write = 1, ior_d = 1. Go to FETCH on mem_ready, else hold with mem_write held at 1.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Go to FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Go to FETCH.
- Unused codes 12-15: all outputs 0, go to FETCH, no count.

Latency (cycles, with mem_ready always 1):
- lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Each cycle mem_ready is low inside FETCH, MEMRD or MEMWR adds one cycle.

Retired counter and illegal flag:
- retired increments by 1 on the clock edge that leaves MEMWB, MEMWR (with mem_ready), ALUWB, ADDIWB, BRANCH or JUMP.
- beq counts whether or not the branch is taken.
- retired wraps modulo 2^CNT_W.
- An illegal opcode does not increment retired.
- illegal_op is 1 for exactly one cycle, while the FSM is in the FETCH that follows the DECODE.

Test Plan:
- Reset then release with mem_ready = 1: state = 0, retired = 0. First cycle shows mem_read = 1, ir_write = 1, pc_write = 1, alu_src_b = 01. Next state = 1.
- lw (opcode 100011) with mem_ready = 1: state sequence 0, 1, 2, 3, 4, 0. Cycle 4 has reg_write = 1, mem_to_reg = 1. retired = 1 after MEMWB.
- sw with mem_ready low for 3 cycles in MEMWR: state holds at 5 with mem_write = 1 for 4 cycles total, then returns to 0 and retired increments once.
- R-type, beq and j back-to-back: sequences 0-1-6-7, 0-1-8, 0-1-11. BRANCH shows alu_op = 01, pc_write_cond = 1, pc_source = 01. JUMP shows pc_source = 10. retired = 3.
- Illegal opcode 111111: path 1 -> 0, illegal_op pulses for 1 cycle, retired unchanged, no write enable asserted in DECODE.
- Counter wrap and mid-instruction reset:
  - CNT_W = 4 with 16 addi instructions (opcode 001000): retired returns to 0.
  - reset_n pulsed low while in MEMRD: state = 0 immediately, all write enables 0 during reset, retired = 0.
